// File: rtl/mux26_cfg_chain.sv
// Configuration chain for a bank of 26:1 routing muxes: serial shift chain,
// frame-length check and a shadow register that drives the mux selects.
module mux26_cfg_chain #(
    parameter  int NUM_MUX = 4,
    parameter  int SEL_W   = 5,
    localparam int TOTAL   = NUM_MUX * SEL_W
) (
    input  logic             prog_clk,
    input  logic             pReset_n,
    input  logic             ccff_head,
    input  logic             cfg_en,
    input  logic             cfg_commit,
    output logic             ccff_tail,
    output logic [0:TOTAL-1] sram,
    output logic [0:TOTAL-1] sram_inv,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int CW = $clog2(TOTAL + 2);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic [0:TOTAL-1] sr_q, sr_d;
    logic [0:TOTAL-1] shd_q, shd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [0:TOTAL-1] sr_shift;
    logic [CW-1:0]    cnt_inc;

    assign sr_shift = {ccff_head, sr_q[0:TOTAL-2]};
    assign cnt_inc  = (cnt_q == CW'(TOTAL + 1)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        shd_d   = shd_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_en) begin
                    sr_d    = sr_shift;
                    cnt_d   = CW'(1);
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end else if (cfg_commit) begin
                    err_d   = 1'b1;
                    done_d  = 1'b0;
                    state_d = ERR;
                end
            end
            LOAD: begin
                // Shift and commit in the same cycle is a protocol violation
                if (cfg_en && cfg_commit) begin
                    err_d   = 1'b1;
                    done_d  = 1'b0;
                    state_d = ERR;
                end else if (cfg_en) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_inc;
                end else if (cfg_commit) begin
                    if (cnt_q == CW'(TOTAL)) begin
                        state_d = COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                        state_d = ERR;
                    end
                end
            end
            COMMIT: begin
                shd_d   = sr_q;
                done_d  = 1'b1;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            ERR: begin
                if (cfg_en) begin
                    sr_d    = sr_shift;
                    cnt_d   = CW'(1);
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            shd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            shd_q   <= shd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ccff_tail = sr_q[TOTAL-1];
    assign sram      = shd_q;
    assign sram_inv  = ~shd_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

endmodule
